// File: rtl/reg_file_param_if.sv
// Register file port bundle: write, dual read, clear and debug bus.
// The master drives requests; the slave is the register file.
interface reg_file_param_if #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 8
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                       Wr_En;
    logic [ADDR_W-1:0]          Wr_Addr;
    logic [DATA_W-1:0]          Wr_Data;
    logic                       Wr_Ready;
    logic [ADDR_W-1:0]          Rd_Addr_A;
    logic [DATA_W-1:0]          Rd_Data_A;
    logic [ADDR_W-1:0]          Rd_Addr_B;
    logic [DATA_W-1:0]          Rd_Data_B;
    logic                       Clr_Req;
    logic                       Busy;
    logic [NUM_REGS*DATA_W-1:0] Regs_Flat;

    modport master (
        output Wr_En, Wr_Addr, Wr_Data,
        output Rd_Addr_A, Rd_Addr_B, Clr_Req,
        input  Wr_Ready, Rd_Data_A, Rd_Data_B,
        input  Busy, Regs_Flat
    );

    modport slave (
        input  Wr_En, Wr_Addr, Wr_Data,
        input  Rd_Addr_A, Rd_Addr_B, Clr_Req,
        output Wr_Ready, Rd_Data_A, Rd_Data_B,
        output Busy, Regs_Flat
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered reads, clear sweep.
// Optional write-through to read ports: define REG_FILE_BYPASS_EN.
module reg_file_param #(
    parameter int DATA_W    = 4,
    parameter int NUM_REGS  = 8,
    parameter int ZERO_REG0 = 1
) (
    input logic             Clk,
    input logic             Reset,
    reg_file_param_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              rdy_q;
    logic              busy;
    logic              wr_fire;
    logic              wr_keep;
    logic              hit_a;
    logic              hit_b;

    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] flat;

    assign busy         = (state == CLEAR);
    assign bus.Busy     = busy;
    assign bus.Wr_Ready = rdy_q & ~busy & ~Reset;
    assign wr_fire      = bus.Wr_En & bus.Wr_Ready;

    // Writes to a hardwired R0 never land and never bypass.
    assign wr_keep = wr_fire &
                     ~((ZERO_REG0 != 0) && (bus.Wr_Addr == '0));

`ifdef REG_FILE_BYPASS_EN
    assign hit_a = wr_keep && (bus.Wr_Addr == bus.Rd_Addr_A);
    assign hit_b = wr_keep && (bus.Wr_Addr == bus.Rd_Addr_B);
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    // Write port is held off until the first edge after reset release.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) rdy_q <= 1'b0;
        else       rdy_q <= 1'b1;
    end

    // Clear sequencer: one register per cycle, NUM_REGS cycles total.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Clr_Req) state <= CLEAR;
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(NUM_REGS - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage: R0 is a constant when hardwired, otherwise a plain register.
    for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
        if ((ZERO_REG0 != 0) && (n == 0)) begin : g_zero
            assign regs[n] = '0;
        end else begin : g_ff
            logic [DATA_W-1:0] q;
            // Clear sweep has priority; writes are blocked while busy anyway.
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset)
                    q <= '0;
                else if (busy && (cnt == ADDR_W'(n)))
                    q <= '0;
                else if (wr_fire && (bus.Wr_Addr == ADDR_W'(n)))
                    q <= bus.Wr_Data;
            end
            assign regs[n] = q;
        end
    end

    // Registered read ports, optionally forwarding the same-edge write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.Rd_Data_A <= '0;
            bus.Rd_Data_B <= '0;
        end else begin
            bus.Rd_Data_A <= hit_a ? bus.Wr_Data : regs[bus.Rd_Addr_A];
            bus.Rd_Data_B <= hit_b ? bus.Wr_Data : regs[bus.Rd_Addr_B];
        end
    end

    // Debug bus straight from storage, never bypassed.
    always_comb begin
        flat = '0;
        for (int i = 0; i < NUM_REGS; i++)
            flat[i*DATA_W +: DATA_W] = regs[i];
    end

    assign bus.Regs_Flat = flat;
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param with a read-data scoreboard.
// A second instance with ZERO_REG0=0 sees the same stimulus.
module tb_reg_file_param;
    logic Clk;
    logic Reset;
    int   passed;
    int   total;
    int   bcnt;
    logic [7:0] sb [$];

    reg_file_param_if #(.DATA_W(4), .NUM_REGS(8)) bus ();
    reg_file_param_if #(.DATA_W(4), .NUM_REGS(8)) bus0 ();

    reg_file_param #(.DATA_W(4), .NUM_REGS(8), .ZERO_REG0(1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    reg_file_param #(.DATA_W(4), .NUM_REGS(8), .ZERO_REG0(0)) dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus0.slave)
    );

    assign bus0.Wr_En     = bus.Wr_En;
    assign bus0.Wr_Addr   = bus.Wr_Addr;
    assign bus0.Wr_Data   = bus.Wr_Data;
    assign bus0.Rd_Addr_A = bus.Rd_Addr_A;
    assign bus0.Rd_Addr_B = bus.Rd_Addr_B;
    assign bus0.Clr_Req   = bus.Clr_Req;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_rd(input logic [3:0] ea, input logic [3:0] eb);
        sb.push_back({ea, eb});
    endtask

    task automatic pop_rd(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_A"}, 32'(bus.Rd_Data_A), 32'(e[7:4]));
            chk({tag, "_B"}, 32'(bus.Rd_Data_B), 32'(e[3:0]));
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        bus.Wr_En   = 1'b1;
        bus.Wr_Addr = a;
        bus.Wr_Data = d;
        tick();
        bus.Wr_En   = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        Reset  = 1'b1;
        bus.Wr_En     = 1'b0;
        bus.Wr_Addr   = '0;
        bus.Wr_Data   = '0;
        bus.Rd_Addr_A = '0;
        bus.Rd_Addr_B = '0;
        bus.Clr_Req   = 1'b0;

        tick();
        chk("rst_ready_low", 32'(bus.Wr_Ready), 32'd0);
        Reset = 1'b0;
        tick();
        chk("rst_ready", 32'(bus.Wr_Ready), 32'd1);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_flat", bus.Regs_Flat, 32'd0);
        chk("rst_rda", 32'(bus.Rd_Data_A), 32'd0);
        chk("rst_rdb", 32'(bus.Rd_Data_B), 32'd0);

        wr(3'd3, 4'hA);
        wr(3'd7, 4'h5);
        bus.Rd_Addr_A = 3'd3;
        bus.Rd_Addr_B = 3'd7;
        push_rd(4'hA, 4'h5);
        tick();
        pop_rd("rd_3_7");
        chk("flat_r3", 32'(bus.Regs_Flat[15:12]), 32'hA);
        chk("flat_r7", 32'(bus.Regs_Flat[31:28]), 32'h5);

        wr(3'd0, 4'hF);
        bus.Rd_Addr_A = 3'd0;
        bus.Rd_Addr_B = 3'd3;
        push_rd(4'h0, 4'hA);
        tick();
        pop_rd("rd_r0_zero");
        chk("flat_r0_zero", 32'(bus.Regs_Flat[3:0]), 32'h0);
        chk("r0_plain_rd", 32'(bus0.Rd_Data_A), 32'hF);
        chk("r0_plain_flat", 32'(bus0.Regs_Flat[3:0]), 32'hF);

        for (int i = 1; i < 8; i++) wr(3'(i), 4'(i));
        chk("fill_flat", bus.Regs_Flat, 32'h7654_3210);
        bus.Clr_Req = 1'b1;
        tick();
        bus.Clr_Req = 1'b0;
        bus.Wr_En   = 1'b1;
        bus.Wr_Addr = 3'd2;
        bus.Wr_Data = 4'hE;
        chk("clr_ready_low", 32'(bus.Wr_Ready), 32'd0);
        bcnt = 0;
        for (int i = 0; i < 20 && bus.Busy; i++) begin
            bcnt++;
            tick();
        end
        bus.Wr_En = 1'b0;
        chk("clr_busy_cycles", 32'(bcnt), 32'd8);
        chk("clr_flat", bus.Regs_Flat, 32'd0);
        chk("clr_busy_done", 32'(bus.Busy), 32'd0);
        chk("clr_ready_back", 32'(bus.Wr_Ready), 32'd1);

        bus.Wr_En     = 1'b1;
        bus.Wr_Addr   = 3'd4;
        bus.Wr_Data   = 4'h9;
        bus.Rd_Addr_A = 3'd4;
        bus.Rd_Addr_B = 3'd4;
`ifdef REG_FILE_BYPASS_EN
        push_rd(4'h9, 4'h9);
`else
        push_rd(4'h0, 4'h0);
`endif
        tick();
        bus.Wr_En = 1'b0;
        pop_rd("byp_same");
        push_rd(4'h9, 4'h9);
        tick();
        pop_rd("byp_next");

        wr(3'd5, 4'h6);
        bus.Clr_Req = 1'b1;
        tick();
        bus.Clr_Req = 1'b0;
        tick();
        tick();
        chk("mid_busy", 32'(bus.Busy), 32'd1);
        chk("mid_r5", 32'(bus.Regs_Flat[23:20]), 32'h6);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_flat", bus.Regs_Flat, 32'd0);
        chk("arst_busy", 32'(bus.Busy), 32'd0);
        chk("arst_ready", 32'(bus.Wr_Ready), 32'd0);
        chk("arst_rda", 32'(bus.Rd_Data_A), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        tick();
        chk("post_busy", 32'(bus.Busy), 32'd0);
        chk("post_ready", 32'(bus.Wr_Ready), 32'd1);
        wr(3'd5, 4'h6);
        bus.Rd_Addr_A = 3'd5;
        bus.Rd_Addr_B = 3'd2;
        push_rd(4'h6, 4'h0);
        tick();
        pop_rd("post_rd5");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
